// File: rtl/llc_plru_ctrl_pkg.sv
// llc_plru_ctrl_pkg: line-level parameters plus the PLRU op, tree and FSM types.
package pkg_line;
  localparam int N_WAY = 16;
  typedef enum logic [1:0] {MESI_I, MESI_S, MESI_E, MESI_M} mesi_e;
endpackage

package pkg_plru;
  import pkg_line::*;
  localparam int PLRU_WAY_W = $clog2(N_WAY);
  typedef enum logic [1:0] {OP_HIT = 2'd0, OP_FILL = 2'd1, OP_PEEK = 2'd2} plru_op_e;
  typedef logic [N_WAY-2:0] plru_tree_t;
  typedef enum logic {ST_INIT, ST_RUN} plru_state_e;
endpackage

// File: rtl/llc_plru_ctrl_tree_next.sv
// plru_tree_next: picks the way for one op and computes the updated heap-indexed PLRU tree.
module plru_tree_next
  import pkg_plru::*;
#(
  parameter int N_WAY = pkg_line::N_WAY,
  parameter int WAY_W = $clog2(N_WAY)
) (
  input  logic [N_WAY-2:0] tree,
  input  logic [1:0]       op,
  input  logic [WAY_W-1:0] way,
  input  logic [N_WAY-1:0] inv_mask,
  output logic [WAY_W-1:0] sel_way,
  output logic             from_inv,
  output logic [N_WAY-2:0] next_tree,
  output logic             wr_en
);
  logic [WAY_W-1:0] inv_way, vic_way, vn, un;
  always_comb begin
    inv_way = '0;
    for (int i = N_WAY - 1; i >= 0; i--) inv_way = inv_mask[i] ? WAY_W'(i) : inv_way;
  end
  // victim walks away from each node's bit: a 0 bit steps right (+2), a 1 bit steps left (+1)
  always_comb begin
    vic_way = '0;
    vn = '0;
    for (int l = 0; l < WAY_W; l++) begin
      vic_way[WAY_W-1-l] = ~tree[vn];
      vn = WAY_W'(2 * int'(vn) + (tree[vn] ? 1 : 2));
    end
  end
  always_comb begin
    next_tree = tree;
    un = '0;
    for (int l = 0; l < WAY_W; l++) begin
      next_tree[un] = sel_way[WAY_W-1-l];
      un = WAY_W'(2 * int'(un) + (sel_way[WAY_W-1-l] ? 2 : 1));
    end
  end
  assign from_inv = (op != OP_HIT) && |inv_mask;
  assign sel_way  = (op == OP_HIT) ? way : from_inv ? inv_way : vic_way;
  assign wr_en    = (op == OP_HIT) || (op == OP_FILL);
endmodule

// File: rtl/llc_plru_ctrl.sv
// llc_plru_ctrl: per-set PLRU array with a 2-stage read/modify/write pipeline and init sweep.
module llc_plru_ctrl
  import pkg_plru::*;
#(
  parameter int N_WAY = pkg_line::N_WAY,
  parameter int N_SET = 256,
  parameter int SET_W = $clog2(N_SET),
  parameter int WAY_W = $clog2(N_WAY)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [SET_W-1:0] req_set,
  input  logic [WAY_W-1:0] req_way,
  input  logic [N_WAY-1:0] req_inv_mask,
  output logic             rsp_valid,
  output logic [WAY_W-1:0] rsp_way,
  output logic             rsp_from_inv
);
  plru_state_e      state_q, state_d;
  logic [SET_W-1:0] cnt_q, cnt_d;
  logic             s1_valid_q, rsp_valid_q, rsp_inv_q;
  logic [1:0]       s1_op_q;
  logic [SET_W-1:0] s1_set_q;
  logic [WAY_W-1:0] s1_way_q, rsp_way_q, sel_way;
  logic [N_WAY-1:0] s1_mask_q;
  logic [N_WAY-2:0] s1_tree_q, next_tree;
  logic [N_WAY-2:0] mem_q [N_SET];
  logic             acc, wr_en, from_inv, s2_wr;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = (state_q == ST_INIT && cnt_q == SET_W'(N_SET - 1)) ? ST_RUN : state_q;
    cnt_d   = (state_q == ST_INIT) ? cnt_q + SET_W'(1) : cnt_q;
  end
  always_comb req_ready = (state_q == ST_RUN);
  assign acc   = req_valid && req_ready;
  assign s2_wr = s1_valid_q && wr_en;
  plru_tree_next #(.N_WAY(N_WAY), .WAY_W(WAY_W)) u_tree_next (
    .tree(s1_tree_q), .op(s1_op_q), .way(s1_way_q), .inv_mask(s1_mask_q),
    .sel_way(sel_way), .from_inv(from_inv), .next_tree(next_tree), .wr_en(wr_en)
  );
  // a same-set write in stage 2 is newer than the array copy being read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_set_q    <= '0;
      s1_way_q    <= '0;
      s1_mask_q   <= '0;
      s1_tree_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_way_q   <= '0;
      rsp_inv_q   <= 1'b0;
    end else begin
      s1_valid_q  <= acc;
      rsp_valid_q <= s1_valid_q;
      if (acc) begin
        s1_op_q   <= req_op;
        s1_set_q  <= req_set;
        s1_way_q  <= req_way;
        s1_mask_q <= req_inv_mask;
        s1_tree_q <= (s2_wr && s1_set_q == req_set) ? next_tree : mem_q[req_set];
      end
      if (s1_valid_q) begin
        rsp_way_q <= sel_way;
        rsp_inv_q <= from_inv;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) mem_q[cnt_q] <= '0;
    else if (s2_wr) mem_q[s1_set_q] <= next_tree;
  end
  assign rsp_valid    = rsp_valid_q;
  assign rsp_way      = rsp_way_q;
  assign rsp_from_inv = rsp_inv_q;
endmodule

// File: tb/tb_llc_plru_ctrl.sv
// tb_llc_plru_ctrl: directed ops on an 8-way controller checked every cycle against a PLRU reference model.
module tb_llc_plru_ctrl;
  localparam int NW = 8, NS = 256, WW = 3, SW = 8;
  logic          clk = 1'b0, rst_n = 1'b1, req_valid = 1'b0, req_ready;
  logic [1:0]    req_op = '0;
  logic [SW-1:0] req_set = '0;
  logic [WW-1:0] req_way = '0;
  logic [NW-1:0] req_inv_mask = '0;
  logic          rsp_valid, rsp_from_inv;
  logic [WW-1:0] rsp_way;
  logic [NW-2:0] u_tree = '0, u_next;
  logic [1:0]    u_op = '0;
  logic [WW-1:0] u_way = '0, u_sel;
  logic [NW-1:0] u_mask = '0;
  logic          u_inv, u_wr;

  always #5 clk = ~clk;

  llc_plru_ctrl #(.N_WAY(NW), .N_SET(NS)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_set(req_set), .req_way(req_way), .req_inv_mask(req_inv_mask),
    .rsp_valid(rsp_valid), .rsp_way(rsp_way), .rsp_from_inv(rsp_from_inv)
  );

  plru_tree_next #(.N_WAY(NW)) u_tn (
    .tree(u_tree), .op(u_op), .way(u_way), .inv_mask(u_mask),
    .sel_way(u_sel), .from_inv(u_inv), .next_tree(u_next), .wr_en(u_wr)
  );

  typedef struct {int due; int way; int inv; int lw; int li;} exp_t;
  exp_t q[$];
  bit   tr[NS][NW-1];
  int   checks = 0, errors = 0, e = 0, rel = 0, lit_w = -1, lit_i = -1;

  task automatic chk(input string n, input int a, input int x);
    checks++;
    if (a != x) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, a, x);
    end
  endtask

  // node at level l on the path of prefix p is (2^l - 1) + p
  function automatic int pick(input int s, input logic [NW-1:0] m);
    int w = 0;
    if (m != 0) begin
      for (int i = NW - 1; i >= 0; i--) if (m[i]) w = i;
      return w;
    end
    for (int l = 0; l < WW; l++) w = 2 * w + (tr[s][(1 << l) - 1 + w] ? 0 : 1);
    return w;
  endfunction

  function automatic void touch(input int s, input int w);
    for (int l = 0; l < WW; l++) tr[s][(1 << l) - 1 + (w >> (WW - l))] = ((w >> (WW - 1 - l)) & 1) != 0;
  endfunction

  always @(posedge clk) begin
    e++;
    rel = rst_n ? rel + 1 : 0;
  end

  always @(negedge clk) begin
    exp_t x;
    int w, inv, o;
    bit ev;
    if (!rst_n) begin
      q.delete();
      foreach (tr[i, j]) tr[i][j] = 1'b0;
    end
    ev = q.size() > 0 && q[0].due == e;
    chk("rsp_valid", int'(rsp_valid), int'(ev));
    chk("req_ready", int'(req_ready), int'(rst_n && rel >= NS));
    if (!rst_n || rel < NS) begin
      chk("init_rsp_way", int'(rsp_way), 0);
      chk("init_rsp_from_inv", int'(rsp_from_inv), 0);
    end
    if (ev) begin
      x = q.pop_front();
      chk("rsp_way", int'(rsp_way), x.way);
      chk("rsp_from_inv", int'(rsp_from_inv), x.inv);
      if (x.lw >= 0) begin
        chk("model_way", x.way, x.lw);
        chk("model_from_inv", x.inv, x.li);
      end
    end
    if (req_valid && req_ready) begin
      o = int'(req_op);
      if (o == 0) begin
        w = int'(req_way);
        inv = 0;
      end else begin
        w = pick(int'(req_set), req_inv_mask);
        inv = int'(req_inv_mask != 0);
      end
      if (o <= 1) touch(int'(req_set), w);
      x = '{e + 2, w, inv, lit_w, lit_i};
      q.push_back(x);
    end
  end

  task automatic send(input int o, input int s, input int w, input int m, input int lw, input int li);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 2'(o); req_set = SW'(s); req_way = WW'(w); req_inv_mask = NW'(m);
    lit_w = lw; lit_i = li;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      req_valid = 1'b0; lit_w = -1; lit_i = -1;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("init_cycles", n, NS);
  endtask

  initial begin
    u_op = 2'd2; #1;
    chk("u_peek_sel", int'(u_sel), 7);
    chk("u_peek_wr", int'(u_wr), 0);
    u_op = 2'd0; u_way = 3'd7; #1;
    chk("u_hit_next", int'(u_next), 'h45);
    chk("u_hit_wr", int'(u_wr), 1);
    u_op = 2'd1; u_mask = 8'h24; #1;
    chk("u_fill_sel", int'(u_sel), 2);
    chk("u_fill_inv", int'(u_inv), 1);
    chk("u_fill_next", int'(u_next), 'h02);
    u_op = 2'd3; #1;
    chk("u_rsv_wr", int'(u_wr), 0);
    chk("u_rsv_sel", int'(u_sel), 2);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready();
    send(2, 0, 0, 0, 7, 0);
    send(0, 0, 7, 0, 7, 0);
    send(2, 0, 0, 0, 3, 0);
    for (int w = 0; w < NW; w++) send(0, 9, w, 0, w, 0);
    send(2, 9, 0, 0, 0, 0);
    send(1, 3, 0, 'h24, 2, 1);
    send(2, 3, 0, 0, 7, 0);
    idle(1);
    send(0, 5, 7, 0, 7, 0);
    send(2, 5, 0, 0, 3, 0);
    send(3, 0, 0, 'h80, 7, 1);
    send(2, 0, 0, 0, 3, 0);
    idle(4);
    send(1, 1, 0, 0, 7, 0);
    @(posedge clk); #1;
    rst_n = 1'b0; req_valid = 1'b0; lit_w = -1; lit_i = -1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wait_ready();
    send(2, 1, 0, 0, 7, 0);
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/llc_plru_ctrl.md
# llc_plru_ctrl

Per-set pseudo-LRU replacement controller for the last-level cache. It keeps the binary-tree PLRU bits of every set in a register array. It accepts one replacement request per cycle from the LLC tag-lookup stage and returns the way to use: the hit way, or a victim on fill. It then writes the updated tree back. It sits directly downstream of tag lookup and upstream of the line-fill/eviction logic.

## Interface
- N_WAY, 16: associativity; power of two, ≥2; taken from pkg_line.
- N_SET, 256: number of sets held in the array.
- SET_W, $clog2(N_SET): set-index width (derived).
- WAY_W, $clog2(N_WAY): way-index width (derived).
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept; reset 0.
- req_op  in  2  plru_op_e: HIT=0, FILL=1, PEEK=2; 3 is reserved and treated as PEEK.
- req_set  in  SET_W  set index.
- req_way  in  WAY_W  accessed way; used for HIT only.
- req_inv_mask  in  N_WAY  bit i=1 means way i is in MESI state I; used for FILL and PEEK.
- rsp_valid  out  1  one-cycle response pulse; reset 0; no backpressure.
- rsp_way  out  WAY_W  selected way; reset 0.
- rsp_from_inv  out  1  way was chosen from req_inv_mask; reset 0.

## Operation
- Tree layout: N_WAY-1 bits per set, heap-indexed. Node 0 is the root; node k has left child 2k+1 and right child 2k+2.
- Update for way w: walk the tree from the root with w's bits, MSB first. Set each visited node to that level's bit of w, then step right if the bit is 1, else left.
- Victim: walk from the root. At each node take direction ~bit and append ~bit to the way index, MSB first.
- HIT: rsp_way=req_way, rsp_from_inv=0; tree updated with req_way.
- FILL: if req_inv_mask≠0, rsp_way is the lowest set bit and rsp_from_inv=1; otherwise rsp_way is the tree victim and rsp_from_inv=0. The tree is updated with rsp_way.
- PEEK: rsp_way is selected as for FILL; the tree is not written.
- Ordering: each op sees the tree state produced by all previously accepted ops, including a same-set op in the immediately preceding cycle.
- FSM states:
  - INIT: req_ready=0. A counter sweeps sets 0..N_SET-1, writing all-zero trees, one set per cycle. After N_SET cycles go to RUN.
  - RUN: req_ready=1; a request is accepted when req_valid&&req_ready.
- Reset asserted at any time (mid-INIT or with ops in flight):
  - FSM returns to INIT and the sweep counter goes to 0.
  - Pipeline valids clear; in-flight requests are dropped and produce no response.
  - Array contents are don't-care until the sweep rewrites them.
- Inputs on cycles without acceptance are ignored.

## Timing
- Stage 1, cycle T: accept. Request fields are registered, and the array entry for req_set is read into a data register at the end of T.
- Stage 2, cycle T+1: victim/update logic is combinational on the stage-1 data. The new tree is written to the array at the end of T+1, and the response registers load.
- Response: rsp_valid=1 in cycle T+2, together with rsp_way and rsp_from_inv. Latency is 2; throughput is one op per cycle.
- Hazard bypass: if stage 2 writes set S in the same cycle that stage 1 reads S, stage 1 takes the stage-2 write data instead of the array output.
- There are no other hazards: the write at T+1 lands before any read issued at T+2.
- The first acceptance is possible in cycle N_SET after rst_n deasserts.

## Structure
- pkg_plru holds:
  - plru_op_e enum;
  - typedef plru_tree_t = logic [N_WAY-2:0];
  - a localparam for WAY_W.
- N_WAY and the MESI enum stay in pkg_line.
- One combinational sub-module, plru_tree_next.
  - Inputs: tree, op, way, inv_mask.
  - Outputs: sel_way, from_inv, next_tree, wr_en.
  - It is instantiated once in stage 2 and also unit-tested on its own.

## Test plan
- Reset: rst_n low, then released. Expected: req_ready stays 0 for exactly 256 cycles, then goes to 1. All outputs are 0 throughout INIT.
- Set 0 after INIT, N_WAY=8:
  - PEEK returns rsp_way=7, from_inv=0.
  - HIT way 7, then PEEK returns way 3.
- Set 9, N_WAY=8: HIT ways 0..7 in consecutive cycles, then PEEK in the next cycle. Expected: rsp_way=0, with each rsp_valid exactly 2 cycles after its accept. This also exercises the back-to-back bypass.
- Invalid preference: FILL on set 3 with inv_mask=8'b0010_0100. Expected: rsp_way=2, from_inv=1. A following PEEK with mask 0 must not return 2.
- Hazard: HIT set 5 way 7 in cycle T, PEEK set 5 in T+1. Expected: the PEEK response in T+3 has way 3, not 7.
- Reset mid-stream: assert rst_n low one cycle after an accepted FILL. Expected: no rsp_valid, the FSM re-enters INIT, and the full 256-cycle sweep repeats.
